predict_update_ctrl: RTL and testbench
======================================

Name: predict_update_ctrl

Overview:
- Sequences all writes into the direct-mapped branch prediction table (18-bit entries: valid, 2-bit state, 2-bit tag, 13-bit target; 2048 entries; single write port).
- Accepts branch resolutions from both E-stage lanes and computes each 2-bit saturating state update.
- Serialises resolutions through a small FIFO onto the one write port.
- Clears the table after reset and on flush requests by sweeping every index.

Parameters:
- DEPTH, 4, pending-update FIFO entries (power of 2, >=2)
- PC_W, 13, word-PC width
- INDEX_W, 11, table index width; tag width = PC_W-INDEX_W

Ports:
- CLK  in  1  clock; all state changes on posedge
- RST  in  1  synchronous active-high reset
- flush  in  1  request full-table clear
- e_val1 / e_val2  in  1  lane1 (older) / lane2 resolved a branch this cycle
- e_pc1 / e_pc2  in  PC_W  branch word-PC
- e_taken1 / e_taken2  in  1  actual outcome
- e_target1 / e_target2  in  PC_W  computed target (e_calcpc)
- e_hit1 / e_hit2  in  1  entry was valid and tag matched at fetch
- e_state1 / e_state2  in  2  state read at fetch
- w_addr  out  INDEX_W  table write index
- w_data  out  18  {valid, state[1:0], tag[1:0], target[12:0]}
- wen  out  1  table write enable
- stall  out  1  pipeline must not present new e_val requests
- busy  out  1  sweep in progress

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous, active-high. All outputs are registered.
- Reset values while RST=1: wen=0, w_addr=0, w_data=0, FIFO count=0, sweep counter=0, state=SWEEP, busy=1, stall=1.
- FSM states: SWEEP, RUN.
- SWEEP behaviour:
  - Each cycle: wen=1, w_data=0, w_addr=sweep counter; counter increments.
  - After writing index 2047, go to RUN next cycle; busy and stall drop in that same cycle.
  - Takes exactly 2048 write cycles after RST deasserts.
  - e_val inputs are ignored in SWEEP.
- flush in RUN:
  - Next cycle enters SWEEP with counter=0; FIFO is emptied and pending updates are discarded.
  - Requests arriving in the same cycle as flush are discarded.
  - flush during SWEEP restarts the counter at 0.
- Update filter, per lane:
  - hit=1: taken -> state=min(state+1,3); not taken -> state=max(state-1,0).
  - hit=0 and taken: allocate with state=2'b10.
  - hit=0 and not taken: no write, not enqueued.
  - Enqueued entry: addr=pc[INDEX_W-1:0], data={1, new_state, pc[PC_W-1:INDEX_W], target}.
  - On a not-taken hit, the target field carries e_target as supplied.
- Same-index collision: if both lanes qualify and their indices are equal, only lane2 is enqueued (lane1 dropped).
- Enqueue order: lane1 before lane2. 0, 1 or 2 entries per cycle.
- Dequeue:
  - One entry per cycle in RUN when count>0.
  - Drives wen/w_addr/w_data registered, so a request at edge N into an empty FIFO writes at edge N+1 (wen high during cycle N+1).
  - wen=0 when the FIFO is empty.
- Simultaneous enqueue and dequeue in the same cycle is allowed; count updates by (enq - deq).
- stall = busy | (count_next > DEPTH-2), i.e. fewer than 2 free slots next cycle.
- Overflow: requests presented while stall=1 are dropped; count never exceeds DEPTH and no FIFO entry is corrupted.
- Read-after-write staleness: e_state comes from the fetch-time read. Back-to-back updates to the same index each overwrite the previous one; no merging in the FIFO.
- RST mid-sweep or with a non-empty FIFO: both are discarded and a fresh sweep starts from index 0.

Test Plan:
- Reset, then release RST -> wen=1 for 2048 consecutive cycles with w_addr 0..2047, w_data=0; busy=0 and stall=0 in the following cycle.
- In RUN, lane1 only: pc=13'h0805, taken, target=13'h0100, hit=0 -> one cycle later wen=1, w_addr=11'h005, w_data={1,2'b10,2'b01,13'h0100}.
- Saturation: hit=1, state=3, taken -> written state 3. hit=1, state=0, not taken -> written state 0. hit=0, not taken -> no wen.
- Both lanes qualify with pc1=13'h0010, pc2=13'h0011 -> writes index 0x010 then 0x011 on consecutive cycles. Repeat with pc2=13'h1010 (same index) -> single write carrying lane2's tag 2'b10.
- Two qualifying lanes every cycle from empty FIFO (DEPTH=4) -> stall asserts once count would exceed 2; requests held off by stall produce no writes; order of the remaining writes is preserved.
- flush asserted with 3 entries pending -> none of the 3 are written; busy=1 next cycle; sweep restarts at index 0. RST asserted mid-sweep at index 500 -> sweep restarts at 0.

Source files
------------

// File: rtl/predict_update_if.sv
// predict_update_if
//   Bundles the E-stage branch-resolution inputs and the prediction-table
//   write port of predict_update_ctrl.
//   master : pipeline side (drives flush and the e_* lane signals, sees the
//            write port, stall and busy)
//   slave  : predict_update_ctrl side
//   Lane 1 is the older instruction, lane 2 the younger.
//   w_data layout: {valid, state[1:0], tag[TAG_W-1:0], target[PC_W-1:0]}
interface predict_update_if #(
  parameter int PC_W    = 13,
  parameter int INDEX_W = 11
);
  localparam int TAG_W  = PC_W - INDEX_W;
  localparam int DATA_W = 3 + TAG_W + PC_W;

  logic               flush;
  logic               e_val1;
  logic               e_val2;
  logic [PC_W-1:0]    e_pc1;
  logic [PC_W-1:0]    e_pc2;
  logic               e_taken1;
  logic               e_taken2;
  logic [PC_W-1:0]    e_target1;
  logic [PC_W-1:0]    e_target2;
  logic               e_hit1;
  logic               e_hit2;
  logic [1:0]         e_state1;
  logic [1:0]         e_state2;
  logic [INDEX_W-1:0] w_addr;
  logic [DATA_W-1:0]  w_data;
  logic               wen;
  logic               stall;
  logic               busy;

  modport master (
    output flush, e_val1, e_val2, e_pc1, e_pc2, e_taken1, e_taken2,
           e_target1, e_target2, e_hit1, e_hit2, e_state1, e_state2,
    input  w_addr, w_data, wen, stall, busy
  );

  modport slave (
    input  flush, e_val1, e_val2, e_pc1, e_pc2, e_taken1, e_taken2,
           e_target1, e_target2, e_hit1, e_hit2, e_state1, e_state2,
    output w_addr, w_data, wen, stall, busy
  );
endinterface

// File: rtl/predict_update_ctrl.sv
// predict_update_ctrl
//   Owns the single write port of the direct-mapped branch prediction table.
//   After reset (and on flush) it sweeps every index writing zero; in RUN it
//   filters E-stage resolutions from both lanes, computes the 2-bit
//   saturating state, queues the resulting entries in a small FIFO and
//   drains one entry per cycle onto the write port.
//   Ports:
//     CLK  : clock, all state changes on the rising edge
//     RST  : synchronous active-high reset
//     bus  : predict_update_if slave (flush, e_* lanes, w_addr/w_data/wen,
//            stall, busy); all outputs are registered
module predict_update_ctrl #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 13,
  parameter int INDEX_W = 11
) (
  input  logic              CLK,
  input  logic              RST,
  predict_update_if.slave   bus
);
  localparam int TAG_W  = PC_W - INDEX_W;
  localparam int DATA_W = 3 + TAG_W + PC_W;
  localparam int ENT_W  = INDEX_W + DATA_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [INDEX_W-1:0] LAST_IDX  = '1;
  localparam logic [CNT_W-1:0]   STALL_LIM = CNT_W'(DEPTH - 2);

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

  // New 2-bit counter value; a miss can only reach here when taken (allocate).
  function automatic logic [1:0] sat_update(input logic hit, input logic taken,
                                            input logic [1:0] st);
    logic [1:0] r;
    if (!hit) r = 2'b10;
    else if (taken) r = (st == 2'b11) ? 2'b11 : st + 2'b01;
    else r = (st == 2'b00) ? 2'b00 : st - 2'b01;
    return r;
  endfunction

  state_t             state, state_next;
  logic [INDEX_W-1:0] sweep_cnt, sweep_cnt_next;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               wen_r, wen_next;
  logic [INDEX_W-1:0] w_addr_r, w_addr_next;
  logic [DATA_W-1:0]  w_data_r, w_data_next;
  logic               busy_r, busy_next, stall_r, stall_next;
  logic [ENT_W-1:0]   mem [DEPTH];

  logic               q1, q2, use1, use2, accept, deq;
  logic [INDEX_W-1:0] idx1, idx2;
  logic [ENT_W-1:0]   ent1, ent2, slot0, slot1, rd_ent;
  logic               slot0_we, slot1_we;
  logic [1:0]         enq_n;

  // A not-taken miss is never written; qualifying lanes become FIFO entries.
  assign q1   = bus.e_val1 & (bus.e_hit1 | bus.e_taken1);
  assign q2   = bus.e_val2 & (bus.e_hit2 | bus.e_taken2);
  assign idx1 = bus.e_pc1[INDEX_W-1:0];
  assign idx2 = bus.e_pc2[INDEX_W-1:0];
  assign ent1 = {idx1, 1'b1, sat_update(bus.e_hit1, bus.e_taken1, bus.e_state1),
                 bus.e_pc1[PC_W-1:INDEX_W], bus.e_target1};
  assign ent2 = {idx2, 1'b1, sat_update(bus.e_hit2, bus.e_taken2, bus.e_state2),
                 bus.e_pc2[PC_W-1:INDEX_W], bus.e_target2};

  // stall_r guarantees two free slots, so an accepted pair can never overflow.
  assign accept = (state == RUN) & ~bus.flush & ~stall_r;
  // Lane2 is younger and wins a same-index collision.
  assign use1   = accept & q1 & ~(q2 & (idx1 == idx2));
  assign use2   = accept & q2;
  assign slot0_we = use1 | use2;
  assign slot1_we = use1 & use2;
  assign slot0    = use1 ? ent1 : ent2;
  assign slot1    = ent2;
  assign enq_n    = {use1 & use2, use1 ^ use2};
  assign deq      = (state == RUN) & ~bus.flush & (count != '0);
  assign rd_ent   = mem[rd_ptr];

  // Next-state, FIFO bookkeeping and write-port values.
  always_comb begin
    state_next     = state;
    sweep_cnt_next = sweep_cnt;
    rd_ptr_next    = rd_ptr;
    wr_ptr_next    = wr_ptr;
    count_next     = count;
    wen_next       = 1'b0;
    w_addr_next    = w_addr_r;
    w_data_next    = w_data_r;
    case (state)
      SWEEP: begin
        if (bus.flush) begin
          sweep_cnt_next = '0;
        end else begin
          wen_next       = 1'b1;
          w_addr_next    = sweep_cnt;
          w_data_next    = '0;
          sweep_cnt_next = sweep_cnt + INDEX_W'(1);
          if (sweep_cnt == LAST_IDX) state_next = RUN;
          else state_next = SWEEP;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next     = SWEEP;
          sweep_cnt_next = '0;
          rd_ptr_next    = '0;
          wr_ptr_next    = '0;
          count_next     = '0;
        end else begin
          if (deq) begin
            wen_next    = 1'b1;
            w_addr_next = rd_ent[ENT_W-1:DATA_W];
            w_data_next = rd_ent[DATA_W-1:0];
            rd_ptr_next = rd_ptr + PTR_W'(1);
          end else begin
            rd_ptr_next = rd_ptr;
          end
          wr_ptr_next = wr_ptr + PTR_W'(enq_n);
          count_next  = count + CNT_W'(enq_n) - CNT_W'(deq);
        end
      end
      default: begin
        state_next     = SWEEP;
        sweep_cnt_next = '0;
      end
    endcase
    // busy covers the cycle showing the final sweep write, then drops.
    busy_next  = (state_next == SWEEP) | (state == SWEEP);
    stall_next = busy_next | (count_next > STALL_LIM);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wen_r     <= 1'b0;
      w_addr_r  <= '0;
      w_data_r  <= '0;
      busy_r    <= 1'b1;
      stall_r   <= 1'b1;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_cnt_next;
      rd_ptr    <= rd_ptr_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      wen_r     <= wen_next;
      w_addr_r  <= w_addr_next;
      w_data_r  <= w_data_next;
      busy_r    <= busy_next;
      stall_r   <= stall_next;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge CLK) begin
    if (slot0_we) mem[wr_ptr] <= slot0;
    if (slot1_we) mem[wr_ptr + PTR_W'(1)] <= slot1;
  end

  assign bus.wen    = wen_r;
  assign bus.w_addr = w_addr_r;
  assign bus.w_data = w_data_r;
  assign bus.busy   = busy_r;
  assign bus.stall  = stall_r;
endmodule

// File: tb/tb_predict_update_ctrl.sv
// tb_predict_update_ctrl
//   Directed bench for predict_update_ctrl (DEPTH=4, PC_W=13, INDEX_W=11).
//   Inputs change 1 time unit after a rising edge; registered outputs are
//   sampled at that same point, i.e. they show what the last edge produced.
module tb_predict_update_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  predict_update_if #(.PC_W(13), .INDEX_W(11)) bus ();

  predict_update_ctrl #(.DEPTH(4), .PC_W(13), .INDEX_W(11)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_lanes();
    bus.e_val1 = 1'b0; bus.e_pc1 = 13'h0; bus.e_taken1 = 1'b0;
    bus.e_target1 = 13'h0; bus.e_hit1 = 1'b0; bus.e_state1 = 2'b00;
    bus.e_val2 = 1'b0; bus.e_pc2 = 13'h0; bus.e_taken2 = 1'b0;
    bus.e_target2 = 13'h0; bus.e_hit2 = 1'b0; bus.e_state2 = 2'b00;
  endtask

  task automatic lane1(input logic [12:0] pc, input logic taken,
                       input logic [12:0] tgt, input logic hit, input logic [1:0] st);
    bus.e_val1 = 1'b1; bus.e_pc1 = pc; bus.e_taken1 = taken;
    bus.e_target1 = tgt; bus.e_hit1 = hit; bus.e_state1 = st;
  endtask

  task automatic lane2(input logic [12:0] pc, input logic taken,
                       input logic [12:0] tgt, input logic hit, input logic [1:0] st);
    bus.e_val2 = 1'b1; bus.e_pc2 = pc; bus.e_taken2 = taken;
    bus.e_target2 = tgt; bus.e_hit2 = hit; bus.e_state2 = st;
  endtask

  // Expects the next edge to write index 0, then 2047 more zero writes,
  // then busy/stall low with wen low.
  task automatic check_sweep(input string tag);
    int bad = 0;
    int first_bad = -1;
    logic [10:0] exp_a;
    for (int i = 0; i < 2048; i++) begin
      step();
      exp_a = 11'(i);
      if (!(bus.wen === 1'b1 && bus.w_addr === exp_a && bus.w_data === 18'h0
            && bus.busy === 1'b1)) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL %s_sweep: %0d bad sweep cycles (first at index %0d), required 0",
               tag, bad, first_bad);
    end
    step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_busy_drop: busy=%b required 0", tag, bus.busy);
    end
    n_cmp++;
    if (bus.stall !== 1'b0) begin
      n_bad++; $display("FAIL %s_stall_drop: stall=%b required 0", tag, bus.stall);
    end
    n_cmp++;
    if (bus.wen !== 1'b0) begin
      n_bad++; $display("FAIL %s_wen_after: wen=%b required 0", tag, bus.wen);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.flush = 1'b0;
    idle_lanes();
    repeat (3) step();
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_bad++; $display("FAIL rst_wen: wen=%b required 0", bus.wen); end
    n_cmp++;
    if (bus.w_addr !== 11'h0) begin n_bad++; $display("FAIL rst_addr: w_addr=%h required 000", bus.w_addr); end
    n_cmp++;
    if (bus.w_data !== 18'h0) begin n_bad++; $display("FAIL rst_data: w_data=%h required 00000", bus.w_data); end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: busy=%b required 1", bus.busy); end
    n_cmp++;
    if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall: stall=%b required 1", bus.stall); end
    RST = 1'b0;
    check_sweep("reset");
  endtask

  task automatic test_single_alloc();
    logic [17:0] exp_d;
    exp_d = {1'b1, 2'b10, 2'b01, 13'h0100};
    lane1(13'h0805, 1'b1, 13'h0100, 1'b0, 2'b00);
    step();
    idle_lanes();
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_bad++; $display("FAIL alloc_latency: wen=%b required 0", bus.wen); end
    step();
    n_cmp++;
    if ({bus.wen, bus.w_addr, bus.w_data} !== {1'b1, 11'h005, exp_d}) begin
      n_bad++;
      $display("FAIL alloc_write: wen=%b addr=%h data=%h required wen=1 addr=005 data=%h",
               bus.wen, bus.w_addr, bus.w_data, exp_d);
    end
    step();
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_bad++; $display("FAIL alloc_idle: wen=%b required 0", bus.wen); end
  endtask

  task automatic test_saturation();
    logic [12:0] pcs [4];
    logic        tkn [4];
    logic [1:0]  sts [4];
    logic [12:0] tgs [4];
    logic [10:0] e_a [4];
    logic [1:0]  e_s [4];
    logic [1:0]  e_t [4];
    logic [17:0] exp_d;
    pcs = '{13'h0123, 13'h1FFF, 13'h0A40, 13'h0801};
    tkn = '{1'b1, 1'b0, 1'b1, 1'b0};
    sts = '{2'b11, 2'b00, 2'b01, 2'b10};
    tgs = '{13'h0AAA, 13'h1234, 13'h0555, 13'h0000};
    e_a = '{11'h123, 11'h7FF, 11'h240, 11'h001};
    e_s = '{2'b11, 2'b00, 2'b10, 2'b01};
    e_t = '{2'b00, 2'b11, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      lane1(pcs[i], tkn[i], tgs[i], 1'b1, sts[i]);
      step();
      idle_lanes();
      step();
      exp_d = {1'b1, e_s[i], e_t[i], tgs[i]};
      n_cmp++;
      if ({bus.wen, bus.w_addr, bus.w_data} !== {1'b1, e_a[i], exp_d}) begin
        n_bad++;
        $display("FAIL sat_%0d: wen=%b addr=%h data=%h required wen=1 addr=%h data=%h",
                 i, bus.wen, bus.w_addr, bus.w_data, e_a[i], exp_d);
      end
    end
    lane1(13'h0333, 1'b0, 13'h0777, 1'b0, 2'b10);
    step();
    idle_lanes();
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_bad++; $display("FAIL miss_nt_a: wen=%b required 0", bus.wen); end
    step();
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_bad++; $display("FAIL miss_nt_b: wen=%b required 0", bus.wen); end
  endtask

  task automatic test_dual_lane();
    lane1(13'h0010, 1'b1, 13'h00AA, 1'b0, 2'b00);
    lane2(13'h0011, 1'b1, 13'h00BB, 1'b0, 2'b00);
    step();
    idle_lanes();
    step();
    n_cmp++;
    if ({bus.wen, bus.w_addr, bus.w_data} !== {1'b1, 11'h010, 1'b1, 2'b10, 2'b00, 13'h00AA}) begin
      n_bad++; $display("FAIL dual_first: wen=%b addr=%h data=%h required lane1 at 010",
                        bus.wen, bus.w_addr, bus.w_data);
    end
    step();
    n_cmp++;
    if ({bus.wen, bus.w_addr, bus.w_data} !== {1'b1, 11'h011, 1'b1, 2'b10, 2'b00, 13'h00BB}) begin
      n_bad++; $display("FAIL dual_second: wen=%b addr=%h data=%h required lane2 at 011",
                        bus.wen, bus.w_addr, bus.w_data);
    end
    step();
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_bad++; $display("FAIL dual_idle: wen=%b required 0", bus.wen); end
    // same index: lane1 dropped, lane2's tag 2'b10 written
    lane1(13'h0010, 1'b1, 13'h00AA, 1'b0, 2'b00);
    lane2(13'h1010, 1'b1, 13'h00CC, 1'b0, 2'b00);
    step();
    idle_lanes();
    step();
    n_cmp++;
    if ({bus.wen, bus.w_addr, bus.w_data} !== {1'b1, 11'h010, 1'b1, 2'b10, 2'b10, 13'h00CC}) begin
      n_bad++; $display("FAIL collide_write: wen=%b addr=%h data=%h required lane2 at 010",
                        bus.wen, bus.w_addr, bus.w_data);
    end
    step();
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_bad++; $display("FAIL collide_single: wen=%b required 0", bus.wen); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got_a [$];
    logic [17:0] got_d [$];
    logic        exp_stall [6];
    logic [12:0] exp_pc [8];
    logic [12:0] p;
    exp_stall = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_pc = '{13'h0100, 13'h0101, 13'h0102, 13'h0103,
               13'h0106, 13'h0107, 13'h010A, 13'h010B};
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        p = 13'h0100 + 13'(2 * c);
        lane1(p, 1'b1, p, 1'b0, 2'b00);
        lane2(p + 13'h1, 1'b1, p + 13'h1, 1'b0, 2'b00);
      end else begin
        idle_lanes();
      end
      step();
      if (bus.wen === 1'b1) begin
        got_a.push_back(bus.w_addr);
        got_d.push_back(bus.w_data);
      end
      if (c < 6) begin
        n_cmp++;
        if (bus.stall !== exp_stall[c]) begin
          n_bad++; $display("FAIL b2b_stall_%0d: stall=%b required %b", c, bus.stall, exp_stall[c]);
        end
      end
    end
    idle_lanes();
    n_cmp++;
    if (got_a.size() !== 8) begin
      n_bad++; $display("FAIL b2b_count: %0d writes required 8", got_a.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if ({got_a[k], got_d[k]} !== {exp_pc[k][10:0], 1'b1, 2'b10, 2'b00, exp_pc[k]}) begin
          n_bad++; $display("FAIL b2b_write_%0d: addr=%h data=%h required addr=%h target=%h",
                            k, got_a[k], got_d[k], exp_pc[k][10:0], exp_pc[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int stray = 0;
    lane1(13'h0200, 1'b1, 13'h0200, 1'b0, 2'b00);
    lane2(13'h0201, 1'b1, 13'h0201, 1'b0, 2'b00);
    step();
    lane1(13'h0202, 1'b1, 13'h0202, 1'b0, 2'b00);
    lane2(13'h0203, 1'b1, 13'h0203, 1'b0, 2'b00);
    step();
    n_cmp++;
    if ({bus.wen, bus.w_addr} !== {1'b1, 11'h200}) begin
      n_bad++; $display("FAIL flush_pre: wen=%b addr=%h required wen=1 addr=200", bus.wen, bus.w_addr);
    end
    // three entries pending; flush with a same-cycle request
    bus.flush = 1'b1;
    lane1(13'h0204, 1'b1, 13'h0204, 1'b0, 2'b00);
    lane2(13'h0205, 1'b1, 13'h0205, 1'b0, 2'b00);
    step();
    bus.flush = 1'b0;
    idle_lanes();
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_bad++; $display("FAIL flush_wen: wen=%b required 0", bus.wen); end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy: busy=%b required 1", bus.busy); end
    n_cmp++;
    if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL flush_stall: stall=%b required 1", bus.stall); end
    check_sweep("flush");
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.wen === 1'b1) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_bad++; $display("FAIL flush_discard: %0d stray writes required 0", stray); end
  endtask

  task automatic test_rst_mid_sweep();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (501) step();
    n_cmp++;
    if ({bus.wen, bus.w_addr} !== {1'b1, 11'd500}) begin
      n_bad++; $display("FAIL mid_sweep_pos: wen=%b addr=%0d required wen=1 addr=500", bus.wen, bus.w_addr);
    end
    RST = 1'b1;
    step();
    n_cmp++;
    if ({bus.wen, bus.w_addr, bus.busy, bus.stall} !== {1'b0, 11'h0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL mid_rst_state: wen=%b addr=%h busy=%b stall=%b required 0 000 1 1",
                        bus.wen, bus.w_addr, bus.busy, bus.stall);
    end
    RST = 1'b0;
    check_sweep("rst_mid");
  endtask

  initial begin
    test_reset();
    test_single_alloc();
    test_saturation();
    test_dual_lane();
    test_back_to_back();
    test_flush();
    test_rst_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "time limit");
  end
endmodule
